// File: rtl/component_pipe.sv
// component_pipe: elastic, bubble-collapsing valid/ready register pipeline.
// STAGES stages, each with one WIDTH-bit data register and one valid bit.
// A stage loads whenever it is empty or the stage in front of it is loading.
// This lets any bubble be squeezed out by the first upstream stall.
// Optional feature: define COMPONENT_PIPE_STATS_EN to add the 16-bit
// saturating stall_count output. It counts cycles where out_valid && !out_ready.
module component_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              data_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              data_out,
  output logic [STAGES-1:0]             stage_valid,
  output logic [WIDTH-1:0]              data_all_out [0:STAGES],
  output logic [$clog2(STAGES+1)-1:0]   occupancy
`ifdef COMPONENT_PIPE_STATS_EN
  ,
  output logic [15:0]                   stall_count
`endif
);

  localparam int OCC_W = $clog2(STAGES+1);

  logic [STAGES-1:0] v_reg;
  logic [STAGES-1:0] v_next;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] src_v;
  logic [WIDTH-1:0]  d_reg [0:STAGES-1];
  logic [OCC_W-1:0]  occ_reg;
  logic [OCC_W-1:0]  occ_next;

  // Data taps: tap 0 is the upstream input, tap k+1 is the stage k register.
  // Tap k is also the data source that stage k captures from.
  assign data_all_out[0] = data_in;
  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_tap
      assign data_all_out[gi+1] = d_reg[gi];
    end
  endgenerate

  // Load chain, evaluated from the output end back to the input.
  // A stage can take new content if it is empty or its successor is moving.
  always_comb begin
    load = '0;
    load[STAGES-1] = !v_reg[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      load[k] = !v_reg[k] || load[k+1];
    end
  end

  // Valid source for each stage: the input for stage 0, the previous stage otherwise.
  always_comb begin
    src_v    = v_reg << 1;
    src_v[0] = in_valid;
  end

  // Next valid vector and its population count.
  // The count is registered alongside the valid bits, so occupancy always matches stage_valid.
  always_comb begin
    v_next = v_reg;
    for (int k = 0; k < STAGES; k++) begin
      if (load[k]) begin
        v_next[k] = src_v[k];
      end
    end
    if (flush) begin
      v_next = '0;
    end
    occ_next = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ_next = occ_next + OCC_W'(v_next[k]);
    end
  end

  // Valid bits and occupancy; flush only clears valids, rst clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_reg   <= '0;
      occ_reg <= '0;
    end else begin
      v_reg   <= v_next;
      occ_reg <= occ_next;
    end
  end

  // Stage data: capture only a valid item on load, otherwise hold.
  // Flush leaves data untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        d_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k] && src_v[k]) begin
          d_reg[k] <= data_all_out[k];
        end
      end
    end
  end

  assign in_ready    = load[0] && !flush;
  assign out_valid   = v_reg[STAGES-1];
  assign data_out    = d_reg[STAGES-1];
  assign stage_valid = v_reg;
  assign occupancy   = occ_reg;

`ifdef COMPONENT_PIPE_STATS_EN
  logic [15:0] stall_reg;

  // Saturating count of cycles the output is held back by the consumer.
  // Flush does not affect it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_reg <= '0;
    end else if (out_valid && !out_ready && (stall_reg != 16'hFFFF)) begin
      stall_reg <= stall_reg + 16'd1;
    end
  end

  assign stall_count = stall_reg;
`endif

endmodule

// File: tb/tb_component_pipe.sv
// tb_component_pipe: directed bench for component_pipe (WIDTH=8, STAGES=4).
// A queue-based reference model checks the outputs every cycle.
// Directed scenarios pin the model with hand-computed literal values.
// Stall counter checks are included when COMPONENT_PIPE_STATS_EN is defined.
module tb_component_pipe;
  localparam int WIDTH  = 8;
  localparam int STAGES = 4;
  localparam int OCC_W  = $clog2(STAGES+1);

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  data_in;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  data_out;
  logic [STAGES-1:0] stage_valid;
  logic [WIDTH-1:0]  data_all_out [0:STAGES];
  logic [OCC_W-1:0]  occupancy;
`ifdef COMPONENT_PIPE_STATS_EN
  logic [15:0]       stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  component_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_in      (data_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .stage_valid  (stage_valid),
    .data_all_out (data_all_out),
    .occupancy    (occupancy)
`ifdef COMPONENT_PIPE_STATS_EN
    ,
    .stall_count  (stall_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: items in flight, oldest first, with their acceptance cycle.
  // The oldest item is presented once STAGES cycles have passed since it was
  // accepted. Input is accepted while a stage is free, or while the
  // consumer is taking an item from a full pipe.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    int               acc;
  } item_t;

  item_t q[$];
  int    cyc_n   = 0;
  int    m_stall = 0;
  logic  exp_ir;
  logic  exp_ov;

  always @(negedge clk) begin : compare
    exp_ov = (q.size() > 0) && (cyc_n >= q[0].acc + STAGES);
    exp_ir = !flush && ((q.size() < STAGES) || out_ready);
    chk("m_in_ready", in_ready, exp_ir);
    chk("m_out_valid", out_valid, exp_ov);
    chk("m_occupancy", occupancy, q.size());
    chk("m_popcount", $countones(stage_valid), q.size());
    chk("m_tap0", data_all_out[0], data_in);
    if (exp_ov) begin
      chk("m_data_out", data_out, q[0].data);
    end
`ifdef COMPONENT_PIPE_STATS_EN
    chk("m_stall_count", stall_count, m_stall);
`endif
    if (rst) begin
      q.delete();
      m_stall = 0;
    end else begin
      if (exp_ov && !out_ready && m_stall < 65535) begin
        m_stall++;
      end
      if (exp_ov && out_ready) begin
        $display("out cycle %0d data 0x%02h", cyc_n, q[0].data);
        void'(q.pop_front());
      end
      if (flush) begin
        q.delete();
      end else if (in_valid && exp_ir) begin
        $display("in  cycle %0d data 0x%02h", cyc_n, data_in);
        q.push_back('{data: data_in, acc: cyc_n});
      end
    end
    cyc_n++;
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; data_in = '0; out_ready = 1'b0;
    cyc();
    cyc();
    // Reset state
    @(negedge clk);
    chk("rst_stage_valid", stage_valid, 4'h0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    for (int k = 1; k <= STAGES; k++) chk("rst_data", data_all_out[k], 0);
    cyc();
    rst = 1'b0;

    // Single item latency: accepted at cycle 0, presented at cycle 4
    out_ready = 1'b1; in_valid = 1'b1; data_in = 8'h11;
    @(negedge clk); chk("a_in_ready", in_ready, 1);
    cyc(); in_valid = 1'b0; data_in = 8'h00;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); chk("a_occ_mid", occupancy, 1); chk("a_out_valid_mid", out_valid, 0);
      cyc();
    end
    @(negedge clk); chk("a_out_valid", out_valid, 1); chk("a_data_out", data_out, 8'h11);
    cyc();
    @(negedge clk); chk("a_empty", occupancy, 0);
    cyc();

    // Back-to-back stream 0x01..0x0A at full throughput
    for (int i = 0; i < 15; i++) begin
      in_valid = (i < 10);
      data_in  = (i < 10) ? 8'(i + 1) : 8'h00;
      @(negedge clk);
      if (i < 10) chk("b_in_ready", in_ready, 1);
      if (i >= 4 && i <= 13) begin
        chk("b_out_valid", out_valid, 1);
        chk("b_data_out", data_out, 32'(i - 3));
      end
      cyc();
    end

    // Backpressure: 4 items fill the pipe, the 5th waits, then everything drains in order
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; data_in = 8'(8'h21 + i);
      @(negedge clk); chk("c_in_ready_fill", in_ready, 1);
      cyc();
    end
    data_in = 8'h25;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("c_in_ready_full", in_ready, 0);
      chk("c_occ_full", occupancy, 4);
      chk("c_stage_valid_full", stage_valid, 4'hF);
      chk("c_data_out_held", data_out, 8'h21);
      cyc();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("c_in_ready_pass", in_ready, 1);
    chk("c_data_out_first", data_out, 8'h21);
    chk("c_occ_pass", occupancy, 4);
    cyc(); in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); chk("c_out_valid_drain", out_valid, 1); chk("c_data_out_drain", data_out, 8'(8'h21 + i));
      cyc();
    end
    @(negedge clk); chk("c_empty", occupancy, 0);
    cyc();

    // Bubble collapse: items at stages 3 and 1, a new item closes the gap
    out_ready = 1'b0;
    in_valid = 1'b1; data_in = 8'h31; cyc();
    in_valid = 1'b0; cyc();
    in_valid = 1'b1; data_in = 8'h32; cyc();
    in_valid = 1'b0; cyc();
    in_valid = 1'b1; data_in = 8'h33;
    @(negedge clk); chk("d_stage_valid_gap", stage_valid, 4'b1010); chk("d_in_ready", in_ready, 1);
    cyc(); in_valid = 1'b0;
    @(negedge clk); chk("d_stage_valid_move", stage_valid, 4'b1101);
    cyc();
    @(negedge clk);
    chk("d_stage_valid_packed", stage_valid, 4'b1110);
    chk("d_tap_s1", data_all_out[2], 8'h33);
    chk("d_tap_s2", data_all_out[3], 8'h32);
    chk("d_tap_s3", data_all_out[4], 8'h31);
    cyc(); out_ready = 1'b1;
    @(negedge clk); chk("d_out_p", data_out, 8'h31); cyc();
    @(negedge clk); chk("d_out_q", data_out, 8'h32); cyc();
    @(negedge clk); chk("d_out_r", data_out, 8'h33); cyc();
    @(negedge clk); chk("d_empty", stage_valid, 4'h0); cyc();

    // Flush of a full pipe while an item is offered
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; data_in = 8'(8'h41 + i); cyc();
    end
    in_valid = 1'b1; data_in = 8'h55; flush = 1'b1;
    @(negedge clk); chk("e_in_ready_flush", in_ready, 0); chk("e_stage_valid_full", stage_valid, 4'hF);
    cyc(); flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("e_stage_valid_cleared", stage_valid, 4'h0);
    chk("e_out_valid", out_valid, 0);
    chk("e_occ", occupancy, 0);
    chk("e_data_kept_s3", data_all_out[4], 8'h41);
    chk("e_data_kept_s0", data_all_out[1], 8'h44);
    cyc(); out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); chk("e_no_output", out_valid, 0); cyc();
    end

    // Flush coinciding with an output transfer
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; data_in = 8'(8'h61 + i); flush = (i == 5);
      @(negedge clk);
      if (i == 5) chk("f_data_out_at_flush", data_out, 8'h62);
      cyc();
    end
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk); chk("f_cleared", stage_valid, 4'h0); cyc();

    // Reset mid-operation discards in-flight items and clears data
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; data_in = 8'(8'h71 + i); cyc();
    end
    rst = 1'b1;
    cyc(); rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("g_out_valid", out_valid, 0);
    chk("g_stage_valid", stage_valid, 4'h0);
    chk("g_occ", occupancy, 0);
    for (int k = 1; k <= STAGES; k++) chk("g_data_zero", data_all_out[k], 0);
    cyc();

`ifdef COMPONENT_PIPE_STATS_EN
    // Stall counter: 10 blocked cycles, then cleared by reset
    out_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      in_valid = (i == 0); data_in = 8'h81;
      @(negedge clk);
      if (i == 4) chk("h_stall_start", stall_count, 0);
      cyc();
    end
    @(negedge clk); chk("h_stall_ten", stall_count, 10);
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    @(negedge clk); chk("h_stall_rst", stall_count, 0);
    cyc();
`endif

    // Mixed traffic pattern with a flush in the middle; checked by the model
    for (int i = 0; i < 200; i++) begin
      in_valid  = (i % 5) != 2;
      out_ready = (i % 7) < 4;
      data_in   = 8'(i * 13 + 5);
      flush     = (i == 97);
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (8) cyc();
    @(negedge clk); chk("z_drained", occupancy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
